// File: rtl/serial_add_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sub_ctrl
// Brief    : Bit-serial WIDTH-bit add/subtract sequencer driving one external
//            1-bit full adder/subtractor cell, LSB first, with a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_carry,
  input  logic             fa_diff,
  input  logic             fa_bor
);

  localparam int c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_shadow;
  logic               r_chain;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout;

  logic               w_accept;
  logic               w_run;
  logic               w_last;
  logic               w_bit;
  logic               w_chain_nxt;
  logic [WIDTH-1:0]   w_shadow_nxt;

  assign w_accept     = (r_state == c_ST_IDLE) && start;
  assign w_run        = (r_state == c_ST_RUN);
  assign w_last       = w_run && (r_cnt == c_LAST);
  assign w_bit        = r_op ? fa_diff : fa_sum;
  assign w_chain_nxt  = r_op ? fa_bor  : fa_carry;
  assign w_shadow_nxt = {w_bit, r_shadow[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (start) w_state_nxt = c_ST_RUN;
      c_ST_RUN:  if (r_cnt == c_LAST) w_state_nxt = c_ST_DONE;
      c_ST_DONE: w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output decode; cell inputs are forced low outside RUN
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    fa_a = 1'b0;
    fa_b = 1'b0;
    fa_c = 1'b0;
    case (r_state)
      c_ST_RUN: begin
        busy = 1'b1;
        fa_a = r_a[0];
        fa_b = r_b[0];
        fa_c = r_chain;
      end
      c_ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand shift registers, carry/borrow chain and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_shadow <= '0;
      r_chain  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_op     <= op;
      r_a      <= op_a;
      r_b      <= op_b;
      r_shadow <= '0;
      r_chain  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_run) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_shadow <= w_shadow_nxt;
      r_chain  <= w_chain_nxt;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Visible result only changes on the final bit, so it stays stable during RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_cout   <= 1'b0;
    end else if (w_last) begin
      r_result <= w_shadow_nxt;
      r_cout   <= w_chain_nxt;
    end
  end

  assign result = r_result;
  assign cout   = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_sub_ctrl
// Brief    : Directed self-checking bench for serial_add_sub_ctrl (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_sub_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             fa_a;
  logic             fa_b;
  logic             fa_c;
  logic             fa_sum;
  logic             fa_carry;
  logic             fa_diff;
  logic             fa_bor;

  int n_cmp;
  int n_err;

  serial_add_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .fa_a     (fa_a),
    .fa_b     (fa_b),
    .fa_c     (fa_c),
    .fa_sum   (fa_sum),
    .fa_carry (fa_carry),
    .fa_diff  (fa_diff),
    .fa_bor   (fa_bor)
  );

  // External full adder/subtractor cell
  assign fa_sum   = fa_a ^ fa_b ^ fa_c;
  assign fa_carry = (fa_a & fa_b) | (fa_b & fa_c) | (fa_a & fa_c);
  assign fa_diff  = fa_a ^ fa_b ^ fa_c;
  assign fa_bor   = (~fa_a & fa_b) | (fa_b & fa_c) | (~fa_a & fa_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation; operands are scrambled right after acceptance
  task automatic run_op(input string tag, input logic o, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic ec);
    int cyc;
    bit seen;
    @(negedge clk);
    op = o; op_a = a; op_b = b; start = 1'b1;
    cyc = 0; seen = 0;
    while (!seen && cyc < 30) begin
      step();
      cyc++;
      if (cyc == 1) begin
        start = 1'b0; op = ~o; op_a = ~a; op_b = ~b;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_fa_a0"}, {31'd0, fa_a}, {31'd0, a[0]});
        check({tag, "_fa_b0"}, {31'd0, fa_b}, {31'd0, b[0]});
        check({tag, "_fa_c0"}, {31'd0, fa_c}, 32'd0);
      end
      if (done) seen = 1;
    end
    if (!seen) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, cyc, 32'd9);
      check({tag, "_result"}, {24'd0, result}, {24'd0, er});
      check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
      step();
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int ndone;
    int cyc;
    int t1;
    int t2;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; op = 1'b0; op_a = '0; op_b = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_done",   {31'd0, done},   32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_cout",   {31'd0, cout},   32'd0);
    check("rst_fa",     {29'd0, fa_a, fa_b, fa_c}, 32'd0);

    run_op("add_5a_3c", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0);
    run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1);
    run_op("sub_10_01", 1'b1, 8'h10, 8'h01, 8'h0F, 1'b0);
    run_op("sub_00_01", 1'b1, 8'h00, 8'h01, 8'hFF, 1'b1);

    // Start pulse during RUN must be ignored
    @(negedge clk);
    op = 1'b0; op_a = 8'h5A; op_b = 8'h3C; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    op = 1'b1; op_a = 8'hFF; op_b = 8'h01; start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        ndone++;
        check("ign_result", {24'd0, result}, 32'h96);
        check("ign_cout",   {31'd0, cout},   32'd0);
      end
      step();
    end
    check("ign_done_count", ndone, 32'd1);
    check("ign_busy_end", {31'd0, busy}, 32'd0);

    // Reset during 4th RUN cycle aborts
    run_op("sub_pre_rst", 1'b1, 8'h00, 8'h01, 8'hFF, 1'b1);
    @(negedge clk);
    op = 1'b0; op_a = 8'h12; op_b = 8'h34; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    check("rst_mid_busy",   {31'd0, busy},   32'd0);
    check("rst_mid_done",   {31'd0, done},   32'd0);
    check("rst_mid_result", {24'd0, result}, 32'd0);
    check("rst_mid_cout",   {31'd0, cout},   32'd0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done) ndone++;
    end
    check("rst_mid_no_done", ndone, 32'd0);

    // Back-to-back with start held high
    @(negedge clk);
    op = 1'b0; op_a = 8'h01; op_b = 8'h02; start = 1'b1;
    cyc = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && cyc < 40) begin
      step();
      cyc++;
      if (done && t1 < 0) begin
        t1 = cyc;
        check("b2b_result1", {24'd0, result}, 32'h03);
        op_a = 8'h10; op_b = 8'h20;
      end else if (done) begin
        t2 = cyc;
        check("b2b_result2", {24'd0, result}, 32'h30);
        start = 1'b0;
      end else if (t1 >= 0) begin
        check("b2b_hold", {24'd0, result}, 32'h03);
      end
    end
    if (t2 < 0) check("b2b_timeout", 32'd0, 32'd1);
    else        check("b2b_period", t2 - t1, 32'd10);
    repeat (3) step();
    check("b2b_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
